serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around one full_adder instance (s,c <- a,b,cin).

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder. Build with SERIAL_ADD_OVF_EN defined to add the
// signed-overflow flag (ovf).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is sampled on a rising edge and is accepted only while busy is low
  // (IDLE or DONE). a/b/cin need to be valid only on the accepting edge. A start seen while
  // busy is dropped and is not queued. done pulses for exactly one cycle when sum/cout
  // (and ovf) take their new value.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes LSB-first, one bit per clock.
// The optional signed-overflow output is enabled with SERIAL_ADD_OVF_EN.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus,
  output logic [1:0]     state_dbg
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             load, last_bit;

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  // The new sum bit enters at the MSB; after WIDTH shifts s_next holds the whole sum.
  assign s_next = {fa_s, s_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_next[WIDTH-1:1];
      carry <= fa_c;
      // cnt stops at WIDTH-1; the FSM leaves SHIFT on that edge.
      if (!last_bit) cnt <= cnt + CW'(1);
    end
  end

  // Results change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      bus.ovf  <= 1'b0;
`endif
    end else if (last_bit) begin
      bus.sum  <= s_next;
      bus.cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
      // carry currently holds the carry into the MSB.
      bus.ovf  <= carry ^ fa_c;
`endif
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: table of directed adds, hand-written corner sequences, and random
// traffic checked against a cycle-level arithmetic model.
module tb_serial_adder;
  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact unsigned sum plus signed-range test, returned as {ovf, cout, sum}.
  function automatic logic [W-1:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin);
    int u, sa, sb, s;
    logic o;
    u  = int'(a) + int'(b) + int'(cin);
    sa = int'(a) - (a[WIDTH-1] ? (1 << WIDTH) : 0);
    sb = int'(b) - (b[WIDTH-1] ? (1 << WIDTH) : 0);
    s  = sa + sb + int'(cin);
    o  = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
    return {o, u[WIDTH:0]};
  endfunction

  // Cycle-level model: an add occupies WIDTH edges after acceptance, then one done cycle.
  logic [W-1:0]     exp_q[$];
  int               m_rem  = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_sum  = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0 && exp_q.size() > 0) begin
          {m_ovf, m_cout, m_sum} = exp_q.pop_front();
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_rem = WIDTH;
        exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
      end
    end
  end

  always @(negedge clk) begin
    check("mon_busy", 32'(bus.busy), 32'(m_rem > 0));
    check("mon_done", 32'(bus.done), 32'(m_done));
    check("mon_sum",  32'(bus.sum),  32'(m_sum));
    check("mon_cout", 32'(bus.cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
    check("mon_ovf",  32'(bus.ovf),  32'(m_ovf));
`endif
  end

  task automatic start_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output logic found);
    busy_cnt = 0;
    found    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        found = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    if (!found) check("done_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int   bc;
    logic found;
    int   last_cyc;
    logic [WIDTH:0] t;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(0));
    check("rst_busy",  32'(bus.busy),  32'(0));
    check("rst_done",  32'(bus.done),  32'(0));
    check("rst_sum",   32'(bus.sum),   32'(0));
    check("rst_cout",  32'(bus.cout),  32'(0));
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      start_add(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(bc, found);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(WIDTH));
      check($sformatf("vec%0d_sum", i),  32'(bus.sum),  32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
`ifdef SERIAL_ADD_OVF_EN
      check($sformatf("vec%0d_ovf", i),  32'(bus.ovf),  32'(vecs[i].ovf));
`endif
    end

    // A start during SHIFT is ignored
    start_add(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc, found);
    check("ignore_sum",  32'(bus.sum),  32'(8'h33));
    check("ignore_cout", 32'(bus.cout), 32'(0));
    @(negedge clk);
    check("ignore_no_restart", 32'(bus.busy), 32'(0));

    // start held high across done: back-to-back adds every WIDTH+1 cycles
    ra = 8'hC3; rb = 8'h5E;
    bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.cin = 1'b0;
    last_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_done(bc, found);
      t = {1'b0, ra} + {1'b0, rb};
      check($sformatf("b2b%0d_sum", k),  32'(bus.sum),  32'(t[WIDTH-1:0]));
      check($sformatf("b2b%0d_cout", k), 32'(bus.cout), 32'(t[WIDTH]));
      if (last_cyc >= 0) check($sformatf("b2b%0d_interval", k), 32'(cyc - last_cyc), 32'(WIDTH + 1));
      last_cyc = cyc;
      ra = ra + 8'h37; rb = rb ^ 8'hA5;
      bus.a = ra; bus.b = rb;
      if (k == 2) bus.start = 1'b0;
    end
    @(negedge clk);

    // Reset in the middle of an add
    start_add(8'hAA, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_state", 32'(state_dbg), 32'(0));
    check("midrst_busy",  32'(bus.busy),  32'(0));
    check("midrst_done",  32'(bus.done),  32'(0));
    check("midrst_sum",   32'(bus.sum),   32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    start_add(8'h0F, 8'hF1, 1'b0);
    wait_done(bc, found);
    check("postrst_sum",  32'(bus.sum),  32'(8'h00));
    check("postrst_cout", 32'(bus.cout), 32'(1));

    // Random traffic, including starts that land mid-add
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    check("drain_idle", 32'(bus.busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
